bcrypt_pd_loader: RTL and testbench
===================================

// Module: bcrypt_pd_loader
// PURPOSE
//  Write-side sequencer for the bcrypt core's 32-deep constant-data RAM (PD).
//  - Accepts a valid/ready stream of 32-bit words from the input FIFO.
//  - Drives PD_addr/PD_wr_en/din to fill PD[0..30]:
//    EK(18), const 64, iter_count, salt(4), IDs(2), cmp_data(5).
//  - Raises data_ready for the core. PD[31] is never written; it stays 0.
// PARAMETERS
//  MSB      31  top bit of data word (width MSB+1)
//  N_WORDS  31  words written per load (addresses 0..N_WORDS-1, N_WORDS<=31)
// PORTS
//  CLK         in   1      clock, all logic on posedge
//  RST_N       in   1      asynchronous reset, active low
//  in_data     in   MSB+1  input word
//  in_valid    in   1      in_data valid
//  in_ready    out  1      loader accepts word (handshake = in_valid & in_ready)
//  core_idle   in   1      core is not reading PD; loading may start
//  PD_addr     out  5      PD write address
//  PD_wr_en    out  1      PD write strobe
//  din         out  MSB+1  PD write data
//  data_ready  out  1      PD holds a complete, accepted set
//  core_ack    in   1      core has taken the set (1-cycle pulse)
//  err         out  1      checksum mismatch, sticky (PD_LOAD_CHECKSUM_EN only)
// BEHAVIOUR
//  - Reset (async, RST_N=0): state=IDLE, cnt=0.
//    Outputs: in_ready=0, PD_wr_en=0, PD_addr=0, din=0, data_ready=0, err=0.
//  - All outputs are registered except in_ready, which is (state==LOAD).
//  - FSM:
//    IDLE:  go to LOAD when core_idle=1 and data_ready=0; cnt<=0; err<=0.
//    LOAD:  each handshake writes word cnt, then cnt<=cnt+1.
//           After the handshake with cnt==N_WORDS-1: go to CHECK if
//           PD_LOAD_CHECKSUM_EN is defined, otherwise to READY.
//    CHECK: in_ready=1 for one more word (the checksum word); it is not
//           written to PD. On handshake: match goes to READY; mismatch sets
//           err=1 and goes to IDLE.
//    READY: data_ready=1. On core_ack: data_ready<=0, go to IDLE.
//  - Write timing: a handshake in cycle t gives PD_wr_en=1, PD_addr=cnt,
//    din=in_data during cycle t+1 (RAM commits at the end of t+1).
//    PD_wr_en=0 in every other cycle.
//  - data_ready rises the cycle after the final PD write cycle (t+2 relative
//    to the last data handshake), so the core never sees a partial set.
//  - Stall: in_valid=0 during LOAD holds cnt; no write; no timeout.
//  - Back-to-back words give one write per cycle, with no bubbles.
//  - core_idle is sampled only in IDLE. Deasserting it during LOAD/CHECK is
//    ignored; the load completes.
//  - core_ack outside READY is ignored.
//  - cnt never exceeds N_WORDS-1 in LOAD. PD_addr never equals 31.
//  - Reset mid-load: everything returns to reset values. PD keeps stale data,
//    but data_ready=0 guarantees it is not used.
// CONFIGURATION
//  PD_LOAD_CHECKSUM_EN defined:
//    - XOR accumulator (MSB+1 bits) is cleared on LOAD entry and updated on
//      every data handshake.
//    - Word N_WORDS+1 must equal the accumulated XOR; a mismatch sets err.
//  PD_LOAD_CHECKSUM_EN undefined:
//    - No CHECK state, no accumulator; err tied to 0.
//    - Exactly N_WORDS words are consumed per load.
// TESTING
//  1. Reset, core_idle=1, stream words 0x100+k (k=0..30) with in_valid held
//     high -> 31 consecutive PD_wr_en cycles, addr 0..30, din=0x100+k;
//     data_ready=1 two cycles after the last handshake.
//  2. Same stream with in_valid=0 for 3 cycles after word 10 -> no writes
//     in the gap; word 11 goes to addr 11; final PD contents identical.
//  3. In READY, send extra words -> in_ready=0, none accepted.
//     Pulse core_ack -> data_ready=0 next cycle; next load starts at addr 0.
//  4. Assert RST_N=0 after word 15 -> all outputs 0 immediately.
//     Release and reload -> writes restart at addr 0.
//  5. CHECKSUM_EN, checksum word = XOR of words -> data_ready=1, err=0.
//     Corrupted checksum (bit0 flipped) -> err=1, data_ready stays 0,
//     FSM back in IDLE.
//  6. core_idle=0 in IDLE with in_valid=1 -> in_ready=0, no writes,
//     until core_idle=1.

Source files
------------

// File: rtl/bcrypt_pd_loader.sv
// Write-side sequencer that streams 31 constant words into the bcrypt PD RAM and flags data_ready.
// Optional checksum word and sticky err are enabled by defining PD_LOAD_CHECKSUM_EN.
module bcrypt_pd_loader #(
  parameter int MSB     = 31,
  parameter int N_WORDS = 31
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [MSB:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         core_idle,
  output logic [4:0]   PD_addr,
  output logic         PD_wr_en,
  output logic [MSB:0] din,
  output logic         data_ready,
  input  logic         core_ack,
  output logic         err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd3;
  localparam logic [4:0] LAST    = 5'(N_WORDS - 1);

`ifdef PD_LOAD_CHECKSUM_EN
  localparam logic [1:0] S_CHECK     = 2'd2;
  localparam logic [1:0] S_AFTER_LOAD = S_CHECK;
`else
  localparam logic [1:0] S_AFTER_LOAD = S_READY;
`endif

  logic [1:0]   r_state;
  logic [4:0]   r_cnt;
  logic         r_wr_en;
  logic [4:0]   r_addr;
  logic [MSB:0] r_din;
  logic         r_data_ready;
  logic         w_hs;

`ifdef PD_LOAD_CHECKSUM_EN
  logic         r_err;
  logic [MSB:0] r_acc;

  assign in_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign err      = r_err;
`else
  assign in_ready = (r_state == S_LOAD);
  assign err      = 1'b0;
`endif

  assign w_hs       = in_valid & in_ready;
  assign PD_wr_en   = r_wr_en;
  assign PD_addr    = r_addr;
  assign din        = r_din;
  assign data_ready = r_data_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_data_ready <= 1'b0;
`ifdef PD_LOAD_CHECKSUM_EN
      r_err        <= 1'b0;
      r_acc        <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_idle && !r_data_ready) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
`ifdef PD_LOAD_CHECKSUM_EN
            r_err   <= 1'b0;
            r_acc   <= '0;
`endif
          end
        end
        S_LOAD: begin
          // The write lands one cycle after its handshake; cnt saturates at LAST.
          if (w_hs) begin
            r_wr_en <= 1'b1;
            r_addr  <= r_cnt;
            r_din   <= in_data;
`ifdef PD_LOAD_CHECKSUM_EN
            r_acc   <= r_acc ^ in_data;
`endif
            if (r_cnt == LAST) r_state <= S_AFTER_LOAD;
            else               r_cnt   <= r_cnt + 5'd1;
          end
        end
`ifdef PD_LOAD_CHECKSUM_EN
        S_CHECK: begin
          if (w_hs) begin
            if (in_data == r_acc) begin
              r_state <= S_READY;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
`endif
        S_READY: begin
          // First READY cycle covers the final RAM commit before data_ready rises.
          if (!r_data_ready) begin
            r_data_ready <= 1'b1;
          end else if (core_ack) begin
            r_data_ready <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcrypt_pd_loader.sv
// Self-checking bench for bcrypt_pd_loader: directed scenarios plus randomized loads against a
// transaction-level model. Define PD_LOAD_CHECKSUM_EN to exercise the checksum build.
module tb_bcrypt_pd_loader;
  localparam int MSB     = 31;
  localparam int N_WORDS = 31;
`ifdef PD_LOAD_CHECKSUM_EN
  localparam int N_TOT = N_WORDS + 1;
`else
  localparam int N_TOT = N_WORDS;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [MSB:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          core_idle = 1'b0;
  logic [4:0]    PD_addr;
  logic          PD_wr_en;
  logic [MSB:0]  din;
  logic          data_ready;
  logic          core_ack = 1'b0;
  logic          err;

  bcrypt_pd_loader #(.MSB(MSB), .N_WORDS(N_WORDS)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_idle(core_idle), .PD_addr(PD_addr), .PD_wr_en(PD_wr_en), .din(din),
    .data_ready(data_ready), .core_ack(core_ack), .err(err)
  );

  always #5 CLK = ~CLK;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  pd_mem [32];
  logic [31:0]  stim [N_WORDS + 1];

  // Transaction-level model: session active, words taken, pending/raised ready, sticky err.
  bit           m_busy, m_ready, m_pend, m_err, m_wr;
  int           m_taken;
  logic [4:0]   m_addr;
  logic [31:0]  m_data, m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial for (int k = 0; k < 32; k++) pd_mem[k] = '0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_busy <= 0; m_ready <= 0; m_pend <= 0; m_err <= 0; m_wr <= 0;
      m_taken <= 0; m_acc <= '0;
    end else begin
      check("in_ready", in_ready, m_busy);
      check("wr_en", PD_wr_en, m_wr);
      if (m_wr) begin
        check("addr", PD_addr, m_addr);
        check("din", din, m_data);
      end
      check("data_ready", data_ready, m_ready);
      check("err", err, m_err);
      if (PD_wr_en) pd_mem[PD_addr] <= din;

      m_wr <= 1'b0;
      if (m_pend) begin m_ready <= 1; m_pend <= 0; end
      if (m_ready && core_ack) m_ready <= 0;
      if (!m_busy && !m_ready && !m_pend && core_idle) begin
        m_busy <= 1; m_taken <= 0; m_err <= 0; m_acc <= '0;
      end
      if (m_busy && in_valid) begin
        m_taken <= m_taken + 1;
        if (m_taken < N_WORDS) begin
          m_wr <= 1; m_addr <= 5'(m_taken); m_data <= in_data; m_acc <= m_acc ^ in_data;
        end
        if (m_taken + 1 == N_TOT) begin
          m_busy <= 0;
          if (m_taken == N_WORDS && in_data != m_acc) m_err <= 1;
          else                                      m_pend <= 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic fill_stim(input logic [31:0] base, input bit rnd, input bit corrupt);
    logic [31:0] x = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      stim[k] = rnd ? $urandom : base + 32'(k);
      x ^= stim[k];
    end
    stim[N_WORDS] = corrupt ? (x ^ 32'h1) : x;
  endtask

  task automatic drive_load(input int n, input int gap_at, input int gap_len, input bit rnd);
    int i = 0;
    int budget = 0;
    int gap_left = gap_len;
    bit v, took;
    while (i < n && budget < 3000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i == gap_at && gap_left > 0) begin v = 0; gap_left--; end
      in_valid = v;
      in_data  = v ? stim[i] : $urandom;
      if (rnd) begin
        core_idle = ($urandom_range(0, 2) != 0);
        core_ack  = ($urandom_range(0, 7) == 0);
      end
      took = v && in_ready;
      step();
      budget++;
      if (took) i++;
    end
    in_valid = 1'b0;
    core_ack = 1'b0;
    if (i < n) check("load_timeout", i, n);
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!data_ready && b < 200) begin step(); b++; end
    check("ready_seen", data_ready, 1);
  endtask

  task automatic pulse_ack();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    check("ack_clears", data_ready, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, PD_wr_en, 0);
    check({tag, "_addr"}, PD_addr, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit corrupt;
    repeat (3) step();
    check_all_zero("reset");
    RST_N = 1'b1;
    core_idle = 1'b1;

    // Back-to-back stream 0x100+k.
    fill_stim(32'h100, 0, 0);
    drive_load(N_TOT, -1, 0, 0);
    check("t1_ready_not_yet", data_ready, 0);
`ifndef PD_LOAD_CHECKSUM_EN
    check("t1_last_wr", PD_wr_en, 1);
    check("t1_last_addr", PD_addr, 30);
    check("t1_last_din", din, 32'h11E);
`endif
    step();
    check("t1_ready_at_t2", data_ready, 1);
    check("t1_no_wr", PD_wr_en, 0);
    for (int k = 0; k < N_WORDS; k++) check("t1_pd", pd_mem[k], 32'h100 + 32'(k));
    check("t1_pd31", pd_mem[31], 0);

    // Extra words while READY are refused; ack returns to IDLE.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (4) begin step(); check("t3_refused", in_ready, 0); end
    in_valid = 1'b0;
    pulse_ack();

    // Stall of three cycles before word 11.
    for (int k = 0; k < 32; k++) pd_mem[k] = '0;
    drive_load(N_TOT, 11, 3, 0);
    wait_ready();
    check("t2_pd10", pd_mem[10], 32'h10A);
    check("t2_pd11", pd_mem[11], 32'h10B);
    check("t2_pd30", pd_mem[30], 32'h11E);
    check("t2_pd31", pd_mem[31], 0);
    core_idle = 1'b0;
    pulse_ack();

    // core_idle low in IDLE blocks the start of a load.
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    repeat (5) begin
      step();
      check("t6_blocked", in_ready, 0);
      check("t6_no_wr", PD_wr_en, 0);
    end
    in_valid = 1'b0;
    core_idle = 1'b1;

    // Reset after word 15, then a clean reload from address 0.
    fill_stim(32'h200, 0, 0);
    drive_load(16, -1, 0, 0);
    RST_N = 1'b0;
    #1;
    check_all_zero("t4_midreset");
    step();
    RST_N = 1'b1;
    fill_stim(32'h300, 0, 0);
    drive_load(N_TOT, -1, 0, 0);
    wait_ready();
    check("t4_pd0", pd_mem[0], 32'h300);
    check("t4_pd15", pd_mem[15], 32'h30F);
    pulse_ack();

`ifdef PD_LOAD_CHECKSUM_EN
    fill_stim(32'h0, 1, 0);
    drive_load(N_TOT, -1, 0, 0);
    wait_ready();
    check("t5_err_good", err, 0);
    pulse_ack();
    fill_stim(32'h0, 1, 1);
    drive_load(N_TOT, -1, 0, 0);
    core_idle = 1'b0;
    check("t5_err_bad", err, 1);
    check("t5_no_ready", data_ready, 0);
    repeat (3) step();
    check("t5_err_sticky", err, 1);
    check("t5_idle", in_ready, 0);
    core_idle = 1'b1;
`endif

    // Randomized loads: random data, valid gaps, core_idle and stray acks.
    for (int it = 0; it < 20; it++) begin
`ifdef PD_LOAD_CHECKSUM_EN
      corrupt = ($urandom_range(0, 3) == 0);
`else
      corrupt = 1'b0;
`endif
      fill_stim(32'h0, 1, corrupt);
      drive_load(N_TOT, -1, 0, 1);
      core_idle = 1'b1;
      if (!corrupt) begin
        wait_ready();
        repeat ($urandom_range(0, 4)) step();
        pulse_ack();
      end else begin
        repeat (2) step();
      end
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
